// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I decode types, opcodes and the ID/EX payload.
// Used by decode_stage (optional feature macro: DECODE_BYPASS_EN).
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_fmt_t;

  // ID/EX pipeline register payload
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [REG_AW-1:0] rd;
    alu_op_t           alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } idex_t;

  // funct3/funct7[5] to ALU op; SUB only applies to register-register OP
  function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                         input logic       f7b5,
                                         input logic       is_op);
    alu_op_t op;
    case (funct3)
      3'b000:  op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate extraction for every RV32I format.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  // opcode bits never contribute to an immediate
  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  // format-selected immediate
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode and ID/EX pipeline register.
// Optional writeback-to-decode bypass enabled by defining DECODE_BYPASS_EN.
module decode_stage
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   instr,
  input  logic [XLEN-1:0]   pc,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output alu_op_t           out_alu_op,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rd;
  imm_fmt_t          fmt;
  logic [XLEN-1:0]   imm;
  alu_op_t           alu_op;
  logic              reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [XLEN-1:0]   op1, op2;
  idex_t             dec;
  idex_t             idex_d, idex_q;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign in_ready = ~stall;

  imm_gen u_imm_gen (
    .instr (instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  // control decode by opcode class
  always_comb begin
    fmt       = IMM_R;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        fmt       = IMM_U;
        reg_write = 1'b1;
      end
      OPC_JAL: begin
        fmt       = IMM_J;
        reg_write = 1'b1;
        jump      = 1'b1;
      end
      OPC_JALR: begin
        fmt       = IMM_I;
        reg_write = 1'b1;
        jump      = 1'b1;
      end
      OPC_BRANCH: begin
        fmt    = IMM_B;
        alu_op = ALU_SUB;
        branch = 1'b1;
      end
      OPC_LOAD: begin
        fmt       = IMM_I;
        reg_write = 1'b1;
        mem_read  = 1'b1;
      end
      OPC_STORE: begin
        fmt       = IMM_S;
        mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt       = IMM_I;
        alu_op    = alu_decode(funct3, instr[30], 1'b0);
        reg_write = 1'b1;
      end
      OPC_OP: begin
        fmt       = IMM_R;
        alu_op    = alu_decode(funct3, instr[30], 1'b1);
        reg_write = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        fmt = IMM_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    if (rd == '0) reg_write = 1'b0;
  end

`ifdef DECODE_BYPASS_EN
  logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q;

  // forward the in-flight writeback over stale register file data
  assign op1 = (wb_we && wb_rd == rs1 && rs1 != '0) ? wb_data : rf_data1;
  assign op2 = (wb_we && wb_rd == rs2 && rs2 != '0) ? wb_data : rf_data2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
  assign op1 = rf_data1;
  assign op2 = rf_data2;
`endif

  // assemble the decoded payload
  always_comb begin
    dec           = '0;
    dec.valid     = in_valid;
    dec.pc        = pc;
    dec.imm       = imm;
    dec.rs1_val   = op1;
    dec.rs2_val   = op2;
    dec.rd        = rd;
    dec.alu_op    = alu_op;
    dec.reg_write = reg_write;
    dec.mem_read  = mem_read;
    dec.mem_write = mem_write;
    dec.branch    = branch;
    dec.jump      = jump;
    dec.illegal   = illegal;
  end

  // ID/EX next state: flush over stall over load
  always_comb begin
    idex_d = idex_q;
`ifdef DECODE_BYPASS_EN
    rs1_d = rs1_q;
    rs2_d = rs2_q;
`endif
    if (flush) begin
      idex_d.valid = 1'b0;
    end else if (stall) begin
`ifdef DECODE_BYPASS_EN
      if (wb_we && wb_rd != '0 && wb_rd == rs1_q) idex_d.rs1_val = wb_data;
      if (wb_we && wb_rd != '0 && wb_rd == rs2_q) idex_d.rs2_val = wb_data;
`endif
    end else begin
      idex_d = dec;
`ifdef DECODE_BYPASS_EN
      rs1_d = rs1;
      rs2_d = rs2;
`endif
    end
  end

  // ID/EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q        <= '0;
      idex_q.alu_op <= ALU_ADD;
    end else begin
      idex_q <= idex_d;
    end
  end

`ifdef DECODE_BYPASS_EN
  // held source register fields for stall-time refresh
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end
`endif

  assign out_valid     = idex_q.valid;
  assign out_pc        = idex_q.pc;
  assign out_imm       = idex_q.imm;
  assign out_rs1_val   = idex_q.rs1_val;
  assign out_rs2_val   = idex_q.rs2_val;
  assign out_rd        = idex_q.rd;
  assign out_alu_op    = idex_q.alu_op;
  assign out_reg_write = idex_q.reg_write;
  assign out_mem_read  = idex_q.mem_read;
  assign out_mem_write = idex_q.mem_write;
  assign out_branch    = idex_q.branch;
  assign out_jump      = idex_q.jump;
  assign out_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table plus hand sequences for stall, flush, reset.
module tb_decode_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall, flush, wb_we;
  logic [31:0] instr, pc, rf_data1, rf_data2, wb_data;
  logic [4:0]  rs1, rs2, wb_rd, out_rd;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_illegal;
  logic [31:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  alu_op_t     out_alu_op;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .stall(stall), .flush(flush),
    .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
    .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    idex_t       exp;
  } vec_t;

  vec_t  vecs[$];
  idex_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // ctl = {reg_write, mem_read, mem_write, branch, jump, illegal}
  function automatic idex_t mk(logic [31:0] imm, logic [4:0] rd, alu_op_t alu,
                               logic [5:0] ctl);
    idex_t e;
    e = '0;
    e.imm = imm;
    e.rd = rd;
    e.alu_op = alu;
    {e.reg_write, e.mem_read, e.mem_write, e.branch, e.jump, e.illegal} = ctl;
    return e;
  endfunction

  task automatic add_vec(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2,
                         logic we, logic [4:0] wrd, logic [31:0] wd,
                         logic [31:0] v1, logic [31:0] v2, idex_t e);
    vec_t v;
    v.instr = ins; v.rf1 = r1; v.rf2 = r2;
    v.wbwe = we; v.wbrd = wrd; v.wbdata = wd;
    e.valid = 1'b1;
    e.pc = 32'h1000 + 32'(vecs.size() * 4);
    e.rs1_val = v1;
    e.rs2_val = v2;
    v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic idex_t sample();
    idex_t g;
    g.valid = out_valid; g.pc = out_pc; g.imm = out_imm;
    g.rs1_val = out_rs1_val; g.rs2_val = out_rs2_val; g.rd = out_rd;
    g.alu_op = out_alu_op; g.reg_write = out_reg_write;
    g.mem_read = out_mem_read; g.mem_write = out_mem_write;
    g.branch = out_branch; g.jump = out_jump; g.illegal = out_illegal;
    return g;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // push expected, clock once, pop and compare the ID/EX outputs
  task automatic cycle(string name, idex_t e);
    idex_t g, x;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    g = sample();
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      x = sb_q.pop_front();
      if (g !== x) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", name, g, x);
      end
    end
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] p,
                       logic [31:0] r1, logic [31:0] r2,
                       logic we, logic [4:0] wrd, logic [31:0] wd,
                       logic st, logic fl);
    in_valid = v; instr = ins; pc = p; rf_data1 = r1; rf_data2 = r2;
    wb_we = we; wb_rd = wrd; wb_data = wd; stall = st; flush = fl;
  endtask

  initial begin
    idex_t zero, e, held;
    logic [31:0] byp1, byp2;
    zero = '0;
    zero.alu_op = ALU_ADD;

`ifdef DECODE_BYPASS_EN
    byp1 = 32'hDEADBEEF;
    byp2 = 32'h0000_0055;
`else
    byp1 = 32'h0;
    byp2 = 32'h0000_0007;
`endif

    add_vec(32'hFFF00293, 32'hA0, 32'hB0, 0, 0, 0, 32'hA0, 32'hB0,
            mk(32'hFFFFFFFF, 5, ALU_ADD, 6'b100000));              // addi x5,x0,-1
    add_vec(32'h123450B7, 32'hA1, 32'hB1, 0, 0, 0, 32'hA1, 32'hB1,
            mk(32'h12345000, 1, ALU_ADD, 6'b100000));              // lui x1
    add_vec(32'h00000013, 32'hA2, 32'hB2, 0, 0, 0, 32'hA2, 32'hB2,
            mk(32'h0, 0, ALU_ADD, 6'b000000));                     // addi x0 (nop)
    add_vec(32'h002081B3, 32'h0, 32'h7, 1, 1, 32'hDEADBEEF, byp1, 32'h7,
            mk(32'h0, 3, ALU_ADD, 6'b100000));                     // add x3,x1,x2
    add_vec(32'h40208233, 32'hA4, 32'hB4, 0, 0, 0, 32'hA4, 32'hB4,
            mk(32'h0, 4, ALU_SUB, 6'b100000));                     // sub x4
    add_vec(32'h4033D313, 32'hA5, 32'hB5, 0, 0, 0, 32'hA5, 32'hB5,
            mk(32'h403, 6, ALU_SRA, 6'b100000));                   // srai x6,x7,3
    add_vec(32'h0020A423, 32'hA6, 32'hB6, 0, 0, 0, 32'hA6, 32'hB6,
            mk(32'h8, 8, ALU_ADD, 6'b001000));                     // sw x2,8(x1)
    add_vec(32'hFE208EE3, 32'hA7, 32'hB7, 0, 0, 0, 32'hA7, 32'hB7,
            mk(32'hFFFFFFFC, 29, ALU_SUB, 6'b000100));             // beq -4
    add_vec(32'h001000EF, 32'hA8, 32'hB8, 0, 0, 0, 32'hA8, 32'hB8,
            mk(32'h00000800, 1, ALU_ADD, 6'b100010));              // jal x1,+2048
    add_vec(32'hFF812283, 32'hA9, 32'hB9, 0, 0, 0, 32'hA9, 32'hB9,
            mk(32'hFFFFFFF8, 5, ALU_ADD, 6'b110000));              // lw x5,-8(x2)
    add_vec(32'h0FF0000F, 32'hAA, 32'hBA, 0, 0, 0, 32'hAA, 32'hBA,
            mk(32'h0, 0, ALU_ADD, 6'b000000));                     // fence
    add_vec(32'h00000073, 32'hAB, 32'hBB, 0, 0, 0, 32'hAB, 32'hBB,
            mk(32'h0, 0, ALU_ADD, 6'b000000));                     // ecall
    add_vec(32'hFFFFFFFF, 32'hAC, 32'hBC, 0, 0, 0, 32'hAC, 32'hBC,
            mk(32'h0, 31, ALU_ADD, 6'b000001));                    // illegal
    add_vec(32'h0011B493, 32'hAD, 32'hBD, 0, 0, 0, 32'hAD, 32'hBD,
            mk(32'h1, 9, ALU_SLTU, 6'b100000));                    // sltiu x9,x3,1
    add_vec(32'hFFFFF117, 32'hAE, 32'hBE, 0, 0, 0, 32'hAE, 32'hBE,
            mk(32'hFFFFF000, 2, ALU_ADD, 6'b100000));              // auipc x2
    add_vec(32'h40000093, 32'hAF, 32'hBF, 0, 0, 0, 32'hAF, 32'hBF,
            mk(32'h400, 1, ALU_ADD, 6'b100000));                   // addi x1,x0,0x400

    // reset state
    rst = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cycle("reset_init", zero);
    rst = 1'b0;
    #1 chk("in_ready_after_reset", 32'(in_ready), 32'h1);

    // table-driven decode vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1, vecs[i].instr, vecs[i].exp.pc, vecs[i].rf1, vecs[i].rf2,
            vecs[i].wbwe, vecs[i].wbrd, vecs[i].wbdata, 0, 0);
      #1;
      chk($sformatf("rs1_v%0d", i), 32'(rs1), 32'(vecs[i].instr[19:15]));
      chk($sformatf("rs2_v%0d", i), 32'(rs2), 32'(vecs[i].instr[24:20]));
      chk($sformatf("in_ready_v%0d", i), 32'(in_ready), 32'h1);
      cycle($sformatf("vec%0d", i), vecs[i].exp);
    end

    // load add x3,x1,x2 then stall three cycles with new input present
    drive(1, 32'h002081B3, 32'h2000, 32'h11, 32'h7, 0, 0, 0, 0, 0);
    held = mk(32'h0, 3, ALU_ADD, 6'b100000);
    held.valid = 1'b1; held.pc = 32'h2000;
    held.rs1_val = 32'h11; held.rs2_val = 32'h7;
    cycle("stall_load", held);
    drive(1, 32'h123450B7, 32'h2004, 32'h1234, 32'h5678, 0, 0, 0, 1, 0);
    #1 chk("in_ready_stall", 32'(in_ready), 32'h0);
    cycle("stall_c1", held);
    drive(1, 32'h123450B7, 32'h2004, 32'h1234, 32'h5678, 1, 2, 32'h55, 1, 0);
    held.rs2_val = byp2;
    cycle("stall_c2_wb_x2", held);
    drive(1, 32'h123450B7, 32'h2004, 32'h1234, 32'h5678, 1, 0, 32'h99, 1, 0);
    #1 chk("in_ready_stall3", 32'(in_ready), 32'h0);
    cycle("stall_c3_wb_x0", held);

    // flush wins over stall; fields held
    drive(1, 32'h123450B7, 32'h2004, 32'h0, 32'h0, 0, 0, 0, 1, 1);
    held.valid = 1'b0;
    cycle("flush_stall", held);

    // illegal word after the flush
    drive(1, 32'hFFFFFFFF, 32'h2008, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    e = mk(32'h0, 31, ALU_ADD, 6'b000001);
    e.valid = 1'b1; e.pc = 32'h2008;
    cycle("illegal_after_flush", e);

    // flush alone drops valid and keeps the illegal entry's fields
    drive(1, 32'hFFF00293, 32'h200C, 32'h3, 32'h4, 0, 0, 0, 0, 1);
    e.valid = 1'b0;
    cycle("flush_only", e);

    // bubble: fields load, valid follows in_valid
    drive(0, 32'hFFF00293, 32'h2010, 32'h3, 32'h4, 0, 0, 0, 0, 0);
    e = mk(32'hFFFFFFFF, 5, ALU_ADD, 6'b100000);
    e.pc = 32'h2010; e.rs1_val = 32'h3; e.rs2_val = 32'h4;
    cycle("bubble", e);

    // reset while holding a live instruction
    drive(1, 32'h40208233, 32'h2014, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    e = mk(32'h0, 4, ALU_SUB, 6'b100000);
    e.valid = 1'b1; e.pc = 32'h2014; e.rs1_val = 32'h5; e.rs2_val = 32'h6;
    cycle("pre_reset_load", e);
    rst = 1'b1;
    cycle("reset_midstream", zero);
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("in_ready_post_reset", 32'(in_ready), 32'h1);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
